// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] inst_t;

   // Sequencer states: idle after reset, request issued, awaiting data, holding for decode
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam addr_t       RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_INC_DEF   = 4;

   // Instruction addresses are always word aligned; low two bits are dropped
   function automatic addr_t align_word(input addr_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect priority mux: exception/eret beats branch, target forced to a word boundary.
module fetch_redirect_sel
   import fetch_pkg::*;
(
   input  logic  branch_valid_i,
   input  addr_t branch_target_i,
   input  logic  exc_valid_i,
   input  addr_t exc_target_i,
   output logic  redirect_o,
   output addr_t target_o
);

   // Fixed-priority selection of the redirect source
   always_comb begin
      redirect_o = exc_valid_i | branch_valid_i;
      target_o   = align_word(exc_valid_i ? exc_target_i : branch_target_i);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request at a
// time, applies redirects, drops stale responses and holds each word for decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEF,
   parameter int unsigned PC_INC   = PC_INC_DEF
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  stall,
   input  logic  branch_valid,
   input  addr_t branch_target,
   input  logic  exc_valid,
   input  addr_t exc_target,
   output logic  imem_ce,
   output logic  imem_req,
   output addr_t imem_addr,
   input  logic  imem_gnt,
   input  logic  imem_rvalid,
   input  inst_t imem_rdata,
   output logic  inst_valid,
   output addr_t inst_pc,
   output inst_t inst,
   input  logic  id_ready
);

   state_e state_q;
   addr_t  pc_q;
   logic   discard_q;
   logic   inst_valid_q;
   addr_t  inst_pc_q;
   inst_t  inst_q;

   logic   redirect;
   addr_t  target;
   addr_t  pc_inc_d;

   fetch_redirect_sel u_redirect_sel (
      .branch_valid_i  (branch_valid),
      .branch_target_i (branch_target),
      .exc_valid_i     (exc_valid),
      .exc_target_i    (exc_target),
      .redirect_o      (redirect),
      .target_o        (target)
   );

   // Sequential PC step; plain 32-bit add so the top word wraps to zero
   always_comb begin
      pc_inc_d = pc_q + addr_t'(PC_INC);
   end

   // Fetch FSM: state, PC, stale-response flag and the held instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         discard_q    <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_pc_q    <= '0;
         inst_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               if (redirect) pc_q <= target;
            end
            REQ: begin
               // Address only moves on redirect; a grant in the same cycle means the
               // in-flight response belongs to the old PC and must be dropped.
               if (redirect) pc_q <= target;
               if (imem_gnt) begin
                  state_q   <= WAIT;
                  discard_q <= redirect;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (redirect) begin
                     pc_q      <= target;
                     discard_q <= 1'b0;
                     state_q   <= REQ;
                  end else if (discard_q) begin
                     discard_q <= 1'b0;
                     state_q   <= REQ;
                  end else begin
                     inst_q       <= imem_rdata;
                     inst_pc_q    <= pc_q;
                     inst_valid_q <= 1'b1;
                     pc_q         <= pc_inc_d;
                     state_q      <= HOLD;
                  end
               end else if (redirect) begin
                  pc_q      <= target;
                  discard_q <= 1'b1;
               end
            end
            HOLD: begin
               // Redirect wins over both stall and a same-cycle decode accept
               if (redirect) begin
                  inst_valid_q <= 1'b0;
                  pc_q         <= target;
                  state_q      <= REQ;
               end else if (id_ready && !stall) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs come straight from registers or from state decode
   always_comb begin
      imem_ce    = (state_q != IDLE);
      imem_req   = (state_q == REQ);
      imem_addr  = pc_q;
      inst_valid = inst_valid_q;
      inst_pc    = inst_pc_q;
      inst       = inst_q;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall hold, redirects, wrap, async reset.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_valid = 1'b0;
   logic [31:0] branch_target = '0;
   logic        exc_valid = 1'b0;
   logic [31:0] exc_target = '0;
   logic        imem_ce;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst;
   logic        id_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .exc_valid     (exc_valid),
      .exc_target    (exc_target),
      .imem_ce       (imem_ce),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_valid    (inst_valid),
      .inst_pc       (inst_pc),
      .inst          (inst),
      .id_ready      (id_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From REQ: grant, then return one word the next cycle
   task automatic do_fetch(input string tag, input logic [31:0] word);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk({tag, "_wait_req"}, {31'b0, imem_req}, 32'd0);
      chk({tag, "_wait_vld"}, {31'b0, inst_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      step();
      imem_rvalid = 1'b0;
      chk({tag, "_vld"}, {31'b0, inst_valid}, 32'd1);
      chk({tag, "_inst"}, inst, word);
   endtask

   initial begin
      // Async reset mid-cycle, before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_ce",    {31'b0, imem_ce},    32'd0);
      chk("rst_req",   {31'b0, imem_req},   32'd0);
      chk("rst_vld",   {31'b0, inst_valid}, 32'd0);
      chk("rst_addr",  imem_addr,           32'h0);
      chk("rst_inst",  inst,                32'h0);
      chk("rst_ipc",   inst_pc,             32'h0);
      step();
      rst = 1'b0;
      chk("idle_ce", {31'b0, imem_ce}, 32'd0);
      step();
      chk("req0_ce",   {31'b0, imem_ce},  32'd1);
      chk("req0_req",  {31'b0, imem_req}, 32'd1);
      chk("req0_addr", imem_addr,         32'h0);

      // Sequential fetches at 0x0, 0x4, then 0x8 held under stall
      do_fetch("f0", 32'h1111_0001);
      chk("f0_pc", inst_pc, 32'h0);
      id_ready = 1'b1;
      step();
      chk("f0_done_vld", {31'b0, inst_valid}, 32'd0);
      chk("f1_addr", imem_addr, 32'h4);
      do_fetch("f1", 32'h2222_0002);
      chk("f1_pc", inst_pc, 32'h4);
      step();
      chk("f2_addr", imem_addr, 32'h8);
      id_ready = 1'b0;
      do_fetch("f2", 32'h2402_0005);
      stall    = 1'b1;
      id_ready = 1'b1;
      imem_gnt = 1'b1;          // stray grant while holding must be ignored
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_vld",  {31'b0, inst_valid}, 32'd1);
         chk("stall_inst", inst,               32'h2402_0005);
         chk("stall_pc",   inst_pc,            32'h8);
         chk("stall_req",  {31'b0, imem_req},  32'd0);
      end
      imem_gnt = 1'b0;
      stall    = 1'b0;
      step();
      chk("unstall_vld",  {31'b0, inst_valid}, 32'd0);
      chk("unstall_req",  {31'b0, imem_req},   32'd1);
      chk("unstall_addr", imem_addr,           32'hC);

      // Branch while waiting: returned word for 0xC is dropped
      imem_gnt = 1'b1;
      step();
      imem_gnt      = 1'b0;
      branch_valid  = 1'b1;
      branch_target = 32'h100;
      step();
      branch_valid = 1'b0;
      chk("br_wait_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      chk("br_drop_vld", {31'b0, inst_valid}, 32'd0);
      chk("br_req",      {31'b0, imem_req},   32'd1);
      chk("br_addr",     imem_addr,           32'h100);
      do_fetch("f3", 32'h3333_0003);
      chk("f3_pc", inst_pc, 32'h100);
      step();
      chk("f4_addr", imem_addr, 32'h104);

      // Exception beats branch; misaligned exception target is aligned down
      exc_valid     = 1'b1;
      exc_target    = 32'h182;
      branch_valid  = 1'b1;
      branch_target = 32'h200;
      step();
      exc_valid    = 1'b0;
      branch_valid = 1'b0;
      chk("prio_req",  {31'b0, imem_req}, 32'd1);
      chk("prio_addr", imem_addr,         32'h180);

      // Wrap-around from the last word
      branch_valid  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      step();
      branch_valid = 1'b0;
      chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
      do_fetch("f5", 32'h4444_0004);
      chk("f5_pc", inst_pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr", imem_addr, 32'h0);

      // Stray rvalid in REQ is ignored
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000;
      step();
      imem_rvalid = 1'b0;
      chk("spur_vld",  {31'b0, inst_valid}, 32'd0);
      chk("spur_req",  {31'b0, imem_req},   32'd1);
      chk("spur_addr", imem_addr,           32'h0);

      // Redirect in HOLD wins over a same-cycle accept
      do_fetch("f6", 32'h5555_0005);
      chk("f6_pc", inst_pc, 32'h0);
      branch_valid  = 1'b1;
      branch_target = 32'h40;
      step();
      branch_valid = 1'b0;
      chk("hold_br_vld",  {31'b0, inst_valid}, 32'd0);
      chk("hold_br_addr", imem_addr,           32'h40);

      // Async reset while a response is outstanding, then a late rvalid
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("pre_rst_req", {31'b0, imem_req}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_ce",   {31'b0, imem_ce},    32'd0);
      chk("arst_req",  {31'b0, imem_req},   32'd0);
      chk("arst_vld",  {31'b0, inst_valid}, 32'd0);
      chk("arst_addr", imem_addr,           32'h0);
      chk("arst_inst", inst,                32'h0);
      chk("arst_ipc",  inst_pc,             32'h0);
      step();
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h6666_0006;
      step();
      chk("late_vld",  {31'b0, inst_valid}, 32'd0);
      chk("late_req",  {31'b0, imem_req},   32'd1);
      chk("late_addr", imem_addr,           32'h0);
      step();
      imem_rvalid = 1'b0;
      chk("late2_vld",  {31'b0, inst_valid}, 32'd0);
      chk("late2_inst", inst,                32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer. Owns the program counter and drives the instruction-memory request port with a single-outstanding req/gnt/rvalid handshake.
- Applies branch and exception redirects with fixed priority, and discards stale responses.
- Holds each fetched instruction for the decode stage until it is accepted.
- Sits between the hazard/branch units and the instruction ROM/cache, at the front of the CPU pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit; blocks handoff to decode.
- branch_valid  in  1  branch/jump redirect request.
- branch_target  in  32  branch destination.
- exc_valid  in  1  exception/eret redirect; beats branch.
- exc_target  in  32  exception vector or return address.
- imem_ce  out  1  memory enable; 0 in reset/IDLE, 1 otherwise.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (= pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_pc  out  32  address of held instruction.
- inst  out  32  held instruction word.
- id_ready  in  1  decode can accept.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, discard=0.
  - imem_ce, imem_req, inst_valid = 0.
  - inst, inst_pc = 0.
- State machine (registered, all outputs from registers or state decode):
  - IDLE: imem_ce=0. Next cycle -> REQ. A redirect here loads pc=target.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_gnt -> WAIT.
    - Address must not change while req is high and no grant, except on redirect.
  - WAIT: imem_req=0. On imem_rvalid:
    - If discard=1: drop the data, clear discard, -> REQ.
    - Else: latch inst=imem_rdata, inst_pc=pc, inst_valid=1, pc<=pc+PC_INC, -> HOLD.
  - HOLD: inst_valid=1.
    - Transfer occurs when id_ready=1 and stall=0: inst_valid<=0, -> REQ.
    - Otherwise inst, inst_pc and inst_valid stay stable.
- Redirect:
  - redirect = exc_valid | branch_valid.
  - target = exc_valid ? exc_target : branch_target.
  - target[1:0] is forced to 2'b00.
  - Redirect overrides stall.
  - Per-state effect:
    - IDLE: pc<=target, -> REQ.
    - REQ without gnt: pc<=target, stay REQ; the new address is driven next cycle.
    - REQ with gnt in the same cycle: pc<=target, discard<=1, -> WAIT.
    - WAIT without rvalid: pc<=target, discard<=1.
    - WAIT with rvalid in the same cycle: drop the data, pc<=target, discard<=0, -> REQ.
    - HOLD: inst_valid<=0 even if id_ready=1 that cycle, pc<=target, -> REQ.
- Arithmetic:
  - 32-bit unsigned pc increment; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Spurious handshake signals:
  - imem_rvalid outside WAIT is ignored.
  - imem_gnt outside REQ is ignored.
- Throughput: at most one fetch per 3 cycles with a 0-wait memory (REQ -> WAIT -> HOLD). Only one request is ever outstanding.
- Reset mid-operation:
  - An outstanding response is abandoned.
  - An rvalid arriving after reset is ignored in IDLE or REQ.

Decomposition:
- fetch_pkg holds:
  - the state enum {IDLE, REQ, WAIT, HOLD};
  - the PC_INC and RESET_PC defaults;
  - the 32-bit addr_t and inst_t typedefs.
- One sub-module, fetch_redirect_sel: combinational priority mux producing redirect and the aligned target. Everything else stays in fetch_ctrl.

Test Plan:
- Reset release, memory with gnt and rvalid each 1 cycle after the previous step:
  - first imem_addr=0x0;
  - inst_valid rises 3 cycles after IDLE exit, inst_pc=0x0;
  - following fetches at 0x4, 0x8 with id_ready=1.
- Hold under stall: stall=1 for 5 cycles while inst_valid=1 with inst=0x2402_0005 -> inst and inst_pc stable; next REQ only after stall=0.
- Branch during WAIT, branch_target=0x100 -> returned word is discarded (inst_valid stays 0); next imem_addr=0x100; inst_pc=0x100 delivered.
- exc_valid and branch_valid in the same cycle, exc_target=0x180, branch_target=0x200 -> next imem_addr=0x180.
- Wrap-around: redirect to 0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000.
- Async reset asserted in WAIT, then a late rvalid -> all outputs 0 immediately; the late rvalid is ignored; first post-reset imem_addr=RESET_PC.
